// File: rtl/directory_state_engine.sv
// Coherence-state half of one directory bank.
// Holds 8 ways x IDX_CNT coherence entries; decides hit/allocation, next state,
// tag updates and the requests sent to the I$, D$ and memory queues.
// Stage S0 reads the set, stage S1 decides and writes the set back.
module directory_state_engine #(
    parameter int  DATA_SIZE = 4,
    parameter int  TAG_SIZE  = 18,
    parameter int  IDX_CNT   = 512,
    localparam int IDX_ROW   = $clog2(IDX_CNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              op_in,
    input  logic [IDX_ROW-1:0]      idx_in,
    input  logic [TAG_SIZE-1:0]     tag_in,
    input  logic [1:0]              src_in,
    input  logic [1:0]              dest_in,
    input  logic                    st_fwd,
    input  logic [8*TAG_SIZE-1:0]   tag_lines_cur,
    output logic [8*TAG_SIZE-1:0]   tag_lines_next,
    output logic [3:0]              current_state,
    output logic                    mem_instr_q_alloc,
    output logic                    mem_data_q_alloc,
    output logic                    ic_inst_q_alloc,
    output logic                    ic_data_q_alloc,
    output logic                    dc_inst_q_alloc,
    output logic                    dc_data_q_alloc,
    output logic [2:0]              mem_instr_q_operation,
    output logic [2:0]              mem_data_q_operation,
    output logic [2:0]              ic_inst_q_operation,
    output logic [2:0]              ic_data_q_operation,
    output logic [2:0]              dc_inst_q_operation,
    output logic [2:0]              dc_data_q_operation
);

    localparam int SET_W = 8 * DATA_SIZE;

    // directory opcodes
    localparam logic [2:0] DOP_NOOP  = 3'd0;
    localparam logic [2:0] DOP_REPLY = 3'd2;
    localparam logic [2:0] DOP_RD    = 3'd3;
    localparam logic [2:0] DOP_WR    = 3'd4;
    localparam logic [2:0] DOP_INV   = 3'd5;
    localparam logic [2:0] DOP_UPD   = 3'd6;
    localparam logic [2:0] DOP_RWITM = 3'd7;
    // queue operations
    localparam logic [2:0] Q_NOOP = 3'd0;
    localparam logic [2:0] Q_ST   = 3'd2;
    localparam logic [2:0] Q_RD   = 3'd3;
    localparam logic [2:0] Q_WR   = 3'd4;
    localparam logic [2:0] Q_INV  = 3'd5;
    localparam logic [2:0] Q_UPD  = 3'd6;
    localparam logic [2:0] Q_RINV = 3'd7;
    // agents and line states
    localparam logic [1:0] AG_IC = 2'd1;
    localparam logic [1:0] AG_DC = 2'd2;
    localparam logic [1:0] ST_I  = 2'd0;
    localparam logic [1:0] ST_S  = 2'd1;
    localparam logic [1:0] ST_M  = 2'd2;

    // Lowest set bit position of an 8-bit vector (0 when empty).
    function automatic logic [2:0] first_one(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            r = v[i] ? 3'(i) : r;
        end
        return r;
    endfunction

    logic [SET_W-1:0]       r_array [IDX_CNT];
    logic [2:0]             r_op;
    logic [TAG_SIZE-1:0]    r_tag;
    logic [1:0]             r_src;
    logic [1:0]             r_dest;
    logic [IDX_ROW-1:0]     r_idx;
    logic [SET_W-1:0]       r_set;
    logic [2:0]             r_ptr;

    logic [7:0]             w_valid;
    logic [7:0]             w_match;
    logic                   w_hit_any;
    logic                   w_free_any;
    logic                   w_alloc_miss;
    logic [2:0]             w_way;
    logic [3:0]             w_cur;
    logic [3:0]             w_base;
    logic [3:0]             w_new;
    logic [3:0]             w_rem;
    logic [3:0]             w_xmask;
    logic [3:0]             w_ymask;
    logic [2:0]             w_y_req;
    logic [2:0]             w_vic_op;
    logic                   w_write;
    logic [SET_W-1:0]       w_set_next;
    logic [8*TAG_SIZE-1:0]  w_tags_next;
    logic [2:0]             w_ptr_next;
    logic [3:0]             w_cur_out;
    logic [2:0]             w_mi_op;
    logic [2:0]             w_md_op;
    logic [2:0]             w_ii_op;
    logic [2:0]             w_id_op;
    logic [2:0]             w_di_op;
    logic [2:0]             w_dd_op;

    // Per-way valid and tag-match flags of the set held in S1.
    always_comb begin
        w_valid = 8'h00;
        w_match = 8'h00;
        for (int w = 0; w < 8; w++) begin
            w_valid[w] = (r_set[DATA_SIZE*w +: 2] != ST_I);
            w_match[w] = w_valid[w] && (tag_lines_cur[TAG_SIZE*w +: TAG_SIZE] == r_tag);
        end
    end

    // S1 decision: way selection, victim handling, next entry and queue requests.
    always_comb begin
        w_hit_any    = |w_match;
        w_free_any   = ~&w_valid;
        w_way        = w_hit_any ? first_one(w_match)
                                 : (w_free_any ? first_one(~w_valid) : r_ptr);
        w_cur        = r_set[DATA_SIZE*w_way +: 4];
        w_base       = w_hit_any ? w_cur : 4'b0000;   // a freshly allocated line starts as I
        w_xmask      = (r_src == AG_IC) ? 4'b0100 : ((r_src == AG_DC) ? 4'b1000 : 4'b0000);
        w_ymask      = (r_src == AG_IC) ? 4'b1000 : ((r_src == AG_DC) ? 4'b0100 : 4'b0000);
        w_rem        = w_base & ~w_xmask & 4'b1100;
        w_alloc_miss = !w_hit_any &&
                       ((r_op == DOP_RD) || (r_op == DOP_RWITM) || (r_op == DOP_UPD));
        w_vic_op     = (w_cur[1:0] == ST_M) ? Q_RINV : Q_INV;
        w_new        = 4'b0000;
        w_y_req      = Q_NOOP;
        w_write      = 1'b0;
        w_set_next   = r_set;
        w_tags_next  = (r_op != DOP_NOOP) ? tag_lines_cur : {8*TAG_SIZE{1'b0}};
        w_ptr_next   = r_ptr;
        w_cur_out    = 4'b0000;
        w_mi_op      = Q_NOOP;
        w_md_op      = Q_NOOP;
        w_ii_op      = Q_NOOP;
        w_id_op      = Q_NOOP;
        w_di_op      = Q_NOOP;
        w_dd_op      = Q_NOOP;

        // Miss allocation: take the way and, if it was valid, recall it from its holders.
        if (w_alloc_miss) begin
            w_tags_next[TAG_SIZE*w_way +: TAG_SIZE] = r_tag;
            if (!w_free_any) begin
                w_ptr_next = r_ptr + 3'd1;
                w_ii_op    = w_cur[2] ? w_vic_op : Q_NOOP;
                w_di_op    = w_cur[3] ? w_vic_op : Q_NOOP;
            end else begin
                w_ptr_next = r_ptr;
            end
        end else begin
            w_ptr_next = r_ptr;
        end

        case (r_op)
            DOP_RD: begin
                w_mi_op   = Q_RD;
                w_y_req   = ((w_base[1:0] == ST_M) && ((w_base & w_ymask) != 4'b0000)) ? Q_UPD : Q_NOOP;
                w_new     = (w_base & 4'b1100) | w_xmask | {2'b00, ST_S};
                w_write   = 1'b1;
                w_cur_out = w_cur;
            end
            DOP_RWITM, DOP_UPD: begin
                w_mi_op   = ((r_op == DOP_RWITM) || !w_hit_any) ? Q_RD : Q_NOOP;
                w_y_req   = ((w_base & w_ymask) == 4'b0000) ? Q_NOOP :
                            ((w_base[1:0] == ST_M) ? Q_RINV :
                             ((w_base[1:0] == ST_S) ? Q_INV : Q_NOOP));
                w_new     = w_xmask | {2'b00, ST_M};
                w_write   = 1'b1;
                w_cur_out = w_cur;
            end
            DOP_WR, DOP_INV: begin
                w_md_op = (r_op == DOP_WR) ? Q_WR : Q_NOOP;
                if (w_hit_any) begin
                    w_new     = (w_rem == 4'b0000) ? 4'b0000 : (w_rem | {2'b00, w_base[1:0]});
                    w_write   = 1'b1;
                    w_cur_out = w_cur;
                end else begin
                    w_write   = 1'b0;
                end
            end
            DOP_REPLY: begin
                w_id_op = (r_dest == AG_IC) ? Q_ST : Q_NOOP;
                w_dd_op = (r_dest == AG_DC) ? Q_ST : Q_NOOP;
            end
            default: begin
                w_write = 1'b0;
            end
        endcase

        // Requests to the other cache share its inst queue with victim recalls;
        // both only occur on hit and miss respectively, so they never collide.
        w_ii_op = (w_ymask[2] && (w_y_req != Q_NOOP)) ? w_y_req : w_ii_op;
        w_di_op = (w_ymask[3] && (w_y_req != Q_NOOP)) ? w_y_req : w_di_op;

        if (w_write) begin
            w_set_next[DATA_SIZE*w_way +: 4] = w_new;
        end else begin
            w_set_next = r_set;
        end
    end

    // S0 capture: request registers and set read, forwarding the S1 result on back-to-back same line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op   <= DOP_NOOP;
            r_tag  <= {TAG_SIZE{1'b0}};
            r_src  <= 2'd0;
            r_dest <= 2'd0;
            r_idx  <= {IDX_ROW{1'b0}};
            r_set  <= {SET_W{1'b0}};
        end else if (op_in != DOP_NOOP) begin
            r_op   <= op_in;
            r_tag  <= tag_in;
            r_src  <= src_in;
            r_dest <= dest_in;
            r_idx  <= idx_in;
            r_set  <= (st_fwd && (r_op != DOP_NOOP) && (r_idx == idx_in)) ? w_set_next
                                                                            : r_array[idx_in];
        end else begin
            r_op   <= DOP_NOOP;
        end
    end

    // Entry array write-back at the end of S1 and round-robin victim pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IDX_CNT; i++) begin
                r_array[i] <= {SET_W{1'b0}};
            end
            r_ptr <= 3'd0;
        end else begin
            if (w_write) begin
                r_array[r_idx] <= w_set_next;
            end
            r_ptr <= w_ptr_next;
        end
    end

    assign tag_lines_next        = w_tags_next;
    assign current_state         = w_cur_out;
    assign mem_instr_q_operation = w_mi_op;
    assign mem_data_q_operation  = w_md_op;
    assign ic_inst_q_operation   = w_ii_op;
    assign ic_data_q_operation   = w_id_op;
    assign dc_inst_q_operation   = w_di_op;
    assign dc_data_q_operation   = w_dd_op;
    assign mem_instr_q_alloc     = (w_mi_op != Q_NOOP);
    assign mem_data_q_alloc      = (w_md_op != Q_NOOP);
    assign ic_inst_q_alloc       = (w_ii_op != Q_NOOP);
    assign ic_data_q_alloc       = (w_id_op != Q_NOOP);
    assign dc_inst_q_alloc       = (w_di_op != Q_NOOP);
    assign dc_data_q_alloc       = (w_dd_op != Q_NOOP);

endmodule

// File: tb/tb_directory_state_engine.sv
// Directed bench for directory_state_engine with hand-computed expectations.
// The bench plays the external tag store: it supplies the S1 set's tags and
// keeps its own expected tag contents.
module tb_directory_state_engine;

    localparam logic [2:0] D_NOOP = 3'd0, D_REPLY = 3'd2, D_RD = 3'd3, D_WR = 3'd4,
                           D_INV = 3'd5, D_UPD = 3'd6, D_RWITM = 3'd7;
    localparam logic [2:0] Q0 = 3'd0, QST = 3'd2, QRD = 3'd3, QWR = 3'd4,
                           QINV = 3'd5, QUPD = 3'd6, QRINV = 3'd7;
    localparam logic [1:0] IC = 2'd1, DC = 2'd2, MEM = 2'd3;

    logic         clk;
    logic         rst;
    logic [2:0]   op_in;
    logic [8:0]   idx_in;
    logic [17:0]  tag_in;
    logic [1:0]   src_in;
    logic [1:0]   dest_in;
    logic         st_fwd;
    logic [143:0] tag_lines_cur;
    logic [143:0] tag_lines_next;
    logic [3:0]   current_state;
    logic         mem_instr_q_alloc, mem_data_q_alloc, ic_inst_q_alloc;
    logic         ic_data_q_alloc, dc_inst_q_alloc, dc_data_q_alloc;
    logic [2:0]   mem_instr_q_operation, mem_data_q_operation, ic_inst_q_operation;
    logic [2:0]   ic_data_q_operation, dc_inst_q_operation, dc_data_q_operation;

    int           n_checks;
    int           n_errors;
    logic [143:0] store [512];
    logic [8:0]   pend_idx;
    logic [8:0]   s1_idx;

    directory_state_engine dut (
        .clk(clk), .rst(rst), .op_in(op_in), .idx_in(idx_in), .tag_in(tag_in),
        .src_in(src_in), .dest_in(dest_in), .st_fwd(st_fwd),
        .tag_lines_cur(tag_lines_cur), .tag_lines_next(tag_lines_next),
        .current_state(current_state),
        .mem_instr_q_alloc(mem_instr_q_alloc), .mem_data_q_alloc(mem_data_q_alloc),
        .ic_inst_q_alloc(ic_inst_q_alloc), .ic_data_q_alloc(ic_data_q_alloc),
        .dc_inst_q_alloc(dc_inst_q_alloc), .dc_data_q_alloc(dc_data_q_alloc),
        .mem_instr_q_operation(mem_instr_q_operation), .mem_data_q_operation(mem_data_q_operation),
        .ic_inst_q_operation(ic_inst_q_operation), .ic_data_q_operation(ic_data_q_operation),
        .dc_inst_q_operation(dc_inst_q_operation), .dc_data_q_operation(dc_data_q_operation)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue op vector in order {mem_instr, mem_data, ic_inst, ic_data, dc_inst, dc_data}.
    function automatic logic [17:0] qv(input logic [2:0] mi, input logic [2:0] md, input logic [2:0] ii,
                                       input logic [2:0] id, input logic [2:0] di, input logic [2:0] dd);
        return {mi, md, ii, id, di, dd};
    endfunction

    // Next posedge + 1: S1 now holds the previously driven op; supply its tags and drive S0.
    task automatic step(input logic [2:0] op, input logic [8:0] idx, input logic [17:0] tag,
                        input logic [1:0] src, input logic [1:0] dest, input logic fwd);
        @(posedge clk);
        #1;
        s1_idx        = pend_idx;
        tag_lines_cur = store[s1_idx];
        pend_idx      = idx;
        op_in = op; idx_in = idx; tag_in = tag; src_in = src; dest_in = dest; st_fwd = fwd;
    endtask

    // Check the S1 outputs and advance the bench tag store.
    task automatic expect_s1(input string nm, input logic noop, input logic [17:0] eops,
                             input logic chk_cur, input logic [3:0] ecur,
                             input logic do_tag, input int way, input logic [17:0] ntag);
        logic [143:0] etags;
        logic [5:0]   ealloc;
        #2;
        etags  = noop ? 144'd0 : store[s1_idx];
        if (do_tag) etags[18*way +: 18] = ntag;
        ealloc = {|eops[17:15], |eops[14:12], |eops[11:9], |eops[8:6], |eops[5:3], |eops[2:0]};
        check_eq({nm, "_ops"}, {126'd0, mem_instr_q_operation, mem_data_q_operation, ic_inst_q_operation,
                               ic_data_q_operation, dc_inst_q_operation, dc_data_q_operation}, {126'd0, eops});
        check_eq({nm, "_alloc"}, {138'd0, mem_instr_q_alloc, mem_data_q_alloc, ic_inst_q_alloc,
                                 ic_data_q_alloc, dc_inst_q_alloc, dc_data_q_alloc}, {138'd0, ealloc});
        if (chk_cur) check_eq({nm, "_cur"}, {140'd0, current_state}, {140'd0, ecur});
        check_eq({nm, "_tags"}, tag_lines_next, etags);
        if (!noop) store[s1_idx] = etags;
    endtask

    // directed stimulus
    initial begin
        n_checks = 0; n_errors = 0;
        for (int i = 0; i < 512; i++) store[i] = 144'd0;
        pend_idx = 9'd0; s1_idx = 9'd0;
        rst = 1'b0; op_in = D_NOOP; idx_in = 9'd0; tag_in = 18'd0; src_in = 2'd0;
        dest_in = 2'd0; st_fwd = 1'b0; tag_lines_cur = 144'd0;
        #2;
        expect_s1("reset", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b0, 0, 18'd0);
        #8 rst = 1'b1;

        // back-to-back traffic on idx 5, tag 1
        step(D_RD, 9'd5, 18'h1, IC, 2'd0, 1'b0);
        expect_s1("idle", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b0, 0, 18'd0);
        step(D_RD, 9'd5, 18'h1, DC, 2'd0, 1'b1);
        expect_s1("rd_ic_miss", 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b1, 0, 18'h1);
        step(D_RWITM, 9'd5, 18'h1, DC, 2'd0, 1'b1);
        expect_s1("rd_dc_hit", 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0101, 1'b0, 0, 18'd0);
        step(D_RD, 9'd5, 18'h1, IC, 2'd0, 1'b1);
        expect_s1("rwitm_dc", 1'b0, qv(QRD, Q0, QINV, Q0, Q0, Q0), 1'b1, 4'b1101, 1'b0, 0, 18'd0);
        step(D_WR, 9'd5, 18'h1, IC, 2'd0, 1'b1);
        expect_s1("rd_ic_on_m", 1'b0, qv(QRD, Q0, Q0, Q0, QUPD, Q0), 1'b1, 4'b1010, 1'b0, 0, 18'd0);
        step(D_WR, 9'd5, 18'h1, DC, 2'd0, 1'b1);
        expect_s1("wr_ic_shared", 1'b0, qv(Q0, QWR, Q0, Q0, Q0, Q0), 1'b1, 4'b1101, 1'b0, 0, 18'd0);
        step(D_NOOP, 9'd0, 18'h0, 2'd0, 2'd0, 1'b0);
        expect_s1("wr_dc_sole", 1'b0, qv(Q0, QWR, Q0, Q0, Q0, Q0), 1'b1, 4'b1001, 1'b0, 0, 18'd0);
        step(D_RD, 9'd5, 18'h1, IC, 2'd0, 1'b0);
        expect_s1("noop_s1", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b0, 0, 18'd0);
        step(D_REPLY, 9'd5, 18'h0, MEM, DC, 1'b0);
        expect_s1("rd_after_inv", 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b1, 0, 18'h1);
        step(D_WR, 9'd5, 18'h3, IC, 2'd0, 1'b0);
        expect_s1("reply_dc", 1'b0, qv(Q0, Q0, Q0, Q0, Q0, QST), 1'b0, 4'b0000, 1'b0, 0, 18'd0);
        step(D_INV, 9'd5, 18'h3, DC, 2'd0, 1'b0);
        expect_s1("wr_miss", 1'b0, qv(Q0, QWR, Q0, Q0, Q0, Q0), 1'b0, 4'b0000, 1'b0, 0, 18'd0);
        step(D_UPD, 9'd5, 18'h1, IC, 2'd0, 1'b0);
        expect_s1("inv_miss", 1'b0, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b0, 4'b0000, 1'b0, 0, 18'd0);
        step(D_INV, 9'd5, 18'h1, IC, 2'd0, 1'b1);
        expect_s1("upd_hit_sole", 1'b0, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0101, 1'b0, 0, 18'd0);
        step(D_NOOP, 9'd0, 18'h0, 2'd0, 2'd0, 1'b0);
        expect_s1("inv_hit_m", 1'b0, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0110, 1'b0, 0, 18'd0);

        // fill idx 7 with eight distinct tags, then force replacement
        for (int i = 0; i < 8; i++) begin
            step(D_RD, 9'd7, 18'h10 + 18'(i), IC, 2'd0, 1'b1);
            if (i == 0) expect_s1("fill_gap", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b0, 4'b0000, 1'b0, 0, 18'd0);
            else expect_s1($sformatf("fill%0d", i - 1), 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0),
                           1'b1, 4'b0000, 1'b1, i - 1, 18'h10 + 18'(i - 1));
        end
        step(D_RWITM, 9'd7, 18'h10, DC, 2'd0, 1'b1);
        expect_s1("fill7", 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b1, 7, 18'h17);
        step(D_RD, 9'd7, 18'h20, IC, 2'd0, 1'b1);
        expect_s1("rwitm_way0", 1'b0, qv(QRD, Q0, QINV, Q0, Q0, Q0), 1'b1, 4'b0101, 1'b0, 0, 18'd0);
        step(D_RD, 9'd7, 18'h21, DC, 2'd0, 1'b1);
        expect_s1("victim_m_way0", 1'b0, qv(QRD, Q0, Q0, Q0, QRINV, Q0), 1'b1, 4'b1010, 1'b1, 0, 18'h20);
        step(D_RD, 9'd9, 18'h5, IC, 2'd0, 1'b0);
        expect_s1("victim_s_way1", 1'b0, qv(QRD, Q0, QINV, Q0, Q0, Q0), 1'b1, 4'b0101, 1'b1, 1, 18'h21);

        // reset while an op sits in S1 drops it
        step(D_NOOP, 9'd0, 18'h0, 2'd0, 2'd0, 1'b0);
        #1 rst = 1'b0;
        expect_s1("mid_reset", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b0, 0, 18'd0);
        #1 rst = 1'b1;
        step(D_RD, 9'd5, 18'h1, IC, 2'd0, 1'b0);
        expect_s1("post_reset_idle", 1'b1, qv(Q0, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b0, 0, 18'd0);
        step(D_NOOP, 9'd0, 18'h0, 2'd0, 2'd0, 1'b0);
        expect_s1("post_reset_rd", 1'b0, qv(QRD, Q0, Q0, Q0, Q0, Q0), 1'b1, 4'b0000, 1'b1, 0, 18'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
